mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates one shared single-port memory between the core's instruction-fetch requester and its load/store requester. It sits between the datapath's imem/dmem interfaces and the unified memory bus. It allows only one outstanding transaction, routes each response back to the requester that owns it, and gives data priority over fetch, with a bounded-starvation guard for fetch.

## Interface
Parameters:
- ADDR_W, 32, address width on all three ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch is waiting; range 1–15

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch response valid, one-cycle pulse
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response or store ack, one-cycle pulse
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request
- m_we, m_be, m_addr, m_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  forwarded from the selected requester
- m_gnt  in  1  memory accepted m_req this cycle
- m_rvalid  in  1  memory response, exactly one per granted request (stores included)
- m_rdata  in  DATA_W  memory read data
- proto_err  out  1  sticky; set when m_rvalid arrives with no transaction outstanding

## Operation
- FSM states: ARB_IDLE and ARB_BUSY. Registered state: owner (OWNER_I or OWNER_D), starve_cnt (4 bits), proto_err.
- ARB_IDLE:
  - Selection: sel_d = d_req & !(i_req & starve_cnt == STARVE_LIMIT); sel_i = i_req & !sel_d.
  - m_req = i_req | d_req. The m_* fields come from the selected requester. When it is fetch: m_we = 0, m_be = all ones, m_wdata = 0.
  - i_gnt = sel_i & m_gnt and d_gnt = sel_d & m_gnt, both combinational.
  - On m_gnt: owner <= the selected requester, then go to ARB_BUSY.
- ARB_BUSY:
  - m_req = 0, i_gnt = 0, d_gnt = 0.
  - On m_rvalid: if owner is I, drive i_rvalid = 1 and i_rdata = m_rdata; otherwise drive d_rvalid = 1 and d_rdata = m_rdata. Then return to ARB_IDLE.
- Starvation counter, updated only on an accepted grant:
  - Data grant while i_req = 1: starve_cnt +1, saturating at STARVE_LIMIT.
  - Fetch grant: starve_cnt <= 0.
  - In ARB_IDLE with i_req = 0: starve_cnt <= 0.
- m_rvalid in ARB_IDLE: ignored, no requester rvalid is driven, and proto_err <= 1.
- Unrouted rdata outputs are 0. i_rdata and d_rdata are 0 whenever the matching rvalid is 0.
- Requesters dropping req before grant is legal; the arbiter simply re-evaluates next cycle.

## Timing
- Reset values: state ARB_IDLE, owner OWNER_I, starve_cnt 0, proto_err 0. Every output is 0 except m_req/m_* fields, which follow the IDLE equations combinationally.
- Grant latency: same cycle as m_gnt. Zero-wait memory gives a response one cycle after the grant at the earliest.
- Throughput: at most one grant per 2 cycles. The m_rvalid cycle is spent in ARB_BUSY, so a new grant is possible in the following cycle.
- A response is delivered in the same cycle as m_rvalid, with no added latency.
- Reset asserted mid-transaction: the FSM drops to ARB_IDLE immediately. A late m_rvalid after reset release sets proto_err. No rvalid is issued to either requester.
- Both requests arriving in the same cycle as starve_cnt == STARVE_LIMIT: fetch wins.

## Structure
- Add to riscv_pkg: typedef enum arb_state_t {ARB_IDLE, ARB_BUSY} and typedef enum arb_owner_t {OWNER_I, OWNER_D}.
- Single module, with no sub-module. The selection logic and the counter stay inline in mem_arbiter.

## Test plan
- Fetch only, m_gnt = 1, m_rvalid one cycle later with rdata 0x00000013 at i_addr 0x0 -> i_gnt in cycle 0, i_rvalid and i_rdata = 0x13 in cycle 1, d_rvalid = 0.
- i_req and d_req both high in the same cycle, d_we = 1, d_addr 0x100, d_wdata 0xDEADBEEF, d_be 0xF -> d_gnt only, m_we = 1, m_addr 0x100. After m_rvalid, d_rvalid pulses, then fetch is granted.
- d_req and i_req held high continuously, STARVE_LIMIT = 4 -> 4 data grants, then 1 fetch grant, then the pattern repeats; starve_cnt never exceeds 4.
- m_gnt low for 3 cycles with d_req held -> m_req stays 1, d_gnt = 0 for 3 cycles, and owner and state are unchanged until the grant.
- reset_n pulsed low while in ARB_BUSY, then m_rvalid arrives after release -> no i_rvalid/d_rvalid, proto_err = 1 and it stays set until the next reset.
- Memory with 5-cycle latency, alternating loads and fetches -> each rvalid goes only to the matching owner, and m_req = 0 throughout ARB_BUSY.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: arbiter FSM state and transaction owner encodings.
package riscv_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction in flight; data has priority, fetch is protected from starvation.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                proto_err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t state, state_next;
    arb_owner_t owner, owner_next;
    logic [3:0] starve_cnt, starve_cnt_next;
    logic       proto_err_next;
    logic       sel_d, sel_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            owner      <= OWNER_I;
            starve_cnt <= 4'd0;
            proto_err  <= 1'b0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            starve_cnt <= starve_cnt_next;
            proto_err  <= proto_err_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        starve_cnt_next = starve_cnt;
        proto_err_next  = proto_err;
        sel_d           = 1'b0;
        sel_i           = 1'b0;
        m_req           = 1'b0;
        i_gnt           = 1'b0;
        d_gnt           = 1'b0;
        i_rvalid        = 1'b0;
        d_rvalid        = 1'b0;
        i_rdata         = '0;
        d_rdata         = '0;

        case (state)
            ARB_IDLE: begin
                // Fetch overrides data only once it has waited STARVE_LIMIT data grants
                sel_d = d_req & ~(i_req & (starve_cnt == LIMIT));
                sel_i = i_req & ~sel_d;
                m_req = i_req | d_req;
                i_gnt = sel_i & m_gnt;
                d_gnt = sel_d & m_gnt;
                if (m_gnt && (sel_i || sel_d)) begin
                    owner_next = sel_d ? OWNER_D : OWNER_I;
                    state_next = ARB_BUSY;
                end
                if (!i_req || i_gnt) begin
                    starve_cnt_next = 4'd0;
                end else if (d_gnt && starve_cnt != LIMIT) begin
                    starve_cnt_next = starve_cnt + 4'd1;
                end
                // A response with nothing outstanding is dropped but remembered
                if (m_rvalid) begin
                    proto_err_next = 1'b1;
                end
            end
            ARB_BUSY: begin
                if (m_rvalid) begin
                    if (owner == OWNER_I) begin
                        i_rvalid = 1'b1;
                        i_rdata  = m_rdata;
                    end else begin
                        d_rvalid = 1'b1;
                        d_rdata  = m_rdata;
                    end
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase

        m_we    = sel_d & d_we;
        m_be    = sel_d ? d_be : '1;
        m_addr  = sel_d ? d_addr : i_addr;
        m_wdata = sel_d ? d_wdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses into a
// scoreboard queue, an independent monitor pops them as rvalid pulses appear.
module tb_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        proto_err;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; combinational checks follow 1 time unit later
    task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] da, input logic [31:0] dw,
                                 input logic mg, input logic mv, input logic [31:0] mrd);
        @(negedge clk);
        i_req    = ir;
        i_addr   = ia;
        d_req    = dr;
        d_we     = dwe;
        d_be     = dbe;
        d_addr   = da;
        d_wdata  = dw;
        m_gnt    = mg;
        m_rvalid = mv;
        m_rdata  = mrd;
        #1;
    endtask

    task automatic expectResp(input logic is_d, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: pops the scoreboard whenever either requester sees a response
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (reset_n) begin
            if (i_rvalid || d_rvalid) begin
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_rvalid: got i_rvalid=%0b d_rvalid=%0b, wanted none at %0t",
                             i_rvalid, d_rvalid, $time);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("rvalid_to_d", {31'b0, d_rvalid}, {31'b0, e.is_d});
                    checkOutput("rvalid_to_i", {31'b0, i_rvalid}, {31'b0, ~e.is_d});
                    checkOutput("routed_rdata", e.is_d ? d_rdata : i_rdata, e.data);
                    checkOutput("unrouted_rdata", e.is_d ? i_rdata : d_rdata, 32'h0);
                end
            end else begin
                checkOutput("quiet_i_rdata", i_rdata, 32'h0);
                checkOutput("quiet_d_rdata", d_rdata, 32'h0);
            end
        end
    end

    logic exp_d_pat [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic isd;
        reset_n  = 1'b0;
        i_req    = 1'b0;
        i_addr   = 32'h0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = 4'h0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'h0;

        @(negedge clk);
        #1;
        checkOutput("reset_i_gnt", {31'b0, i_gnt}, 32'h0);
        checkOutput("reset_d_gnt", {31'b0, d_gnt}, 32'h0);
        checkOutput("reset_m_req", {31'b0, m_req}, 32'h0);
        checkOutput("reset_proto_err", {31'b0, proto_err}, 32'h0);
        checkOutput("reset_m_be", {28'b0, m_be}, 32'hF);
        @(negedge clk);
        reset_n = 1'b1;

        // Fetch only, zero-wait memory
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("f_i_gnt", {31'b0, i_gnt}, 32'h1);
        checkOutput("f_d_gnt", {31'b0, d_gnt}, 32'h0);
        checkOutput("f_m_req", {31'b0, m_req}, 32'h1);
        checkOutput("f_m_we", {31'b0, m_we}, 32'h0);
        checkOutput("f_m_be", {28'b0, m_be}, 32'hF);
        checkOutput("f_m_addr", m_addr, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000013);
        expectResp(1'b0, 32'h00000013);
        checkOutput("f_busy_m_req", {31'b0, m_req}, 32'h0);

        // Simultaneous requests: data store wins, fetch follows
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        checkOutput("both_d_gnt", {31'b0, d_gnt}, 32'h1);
        checkOutput("both_i_gnt", {31'b0, i_gnt}, 32'h0);
        checkOutput("both_m_we", {31'b0, m_we}, 32'h1);
        checkOutput("both_m_addr", m_addr, 32'h100);
        checkOutput("both_m_wdata", m_wdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        expectResp(1'b1, 32'h0);
        checkOutput("both_busy_i_gnt", {31'b0, i_gnt}, 32'h0);
        applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("after_i_gnt", {31'b0, i_gnt}, 32'h1);
        checkOutput("after_m_addr", m_addr, 32'h80);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000ABCD);
        expectResp(1'b0, 32'h0000ABCD);

        // Memory stalls the grant for three cycles
        for (int w = 0; w < 3; w++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h3, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_m_req", {31'b0, m_req}, 32'h1);
            checkOutput("stall_d_gnt", {31'b0, d_gnt}, 32'h0);
            checkOutput("stall_m_be", {28'b0, m_be}, 32'h3);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'h3, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_end_d_gnt", {31'b0, d_gnt}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h000055AA);
        expectResp(1'b1, 32'h000055AA);

        // Both held: four data grants, then one fetch grant, repeating
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'h1000 + k, 1'b1, 1'b0, 4'hF, 32'h2000 + k, 32'h0, 1'b1, 1'b0, 32'h0);
            checkOutput("starve_d_gnt", {31'b0, d_gnt}, {31'b0, exp_d_pat[k]});
            checkOutput("starve_i_gnt", {31'b0, i_gnt}, {31'b0, ~exp_d_pat[k]});
            applyStimulus(1'b1, 32'h1000 + k, 1'b1, 1'b0, 4'hF, 32'h2000 + k, 32'h0, 1'b0, 1'b1, 32'hC000 + k);
            expectResp(exp_d_pat[k], 32'hC000 + k);
        end

        // Reset in the middle of a load, then a stray response
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_pre_d_gnt", {31'b0, d_gnt}, 32'h1);
        @(negedge clk);
        reset_n = 1'b0;
        d_req   = 1'b0;
        m_gnt   = 1'b0;
        #1;
        checkOutput("rst_mid_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        idleCycle();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
        checkOutput("late_i_rvalid", {31'b0, i_rvalid}, 32'h0);
        checkOutput("late_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        checkOutput("late_err_not_yet", {31'b0, proto_err}, 32'h0);
        for (int w = 0; w < 3; w++) begin
            idleCycle();
            checkOutput("proto_err_sticky", {31'b0, proto_err}, 32'h1);
        end

        // Five-cycle memory latency, alternating loads and fetches
        for (int k = 0; k < 4; k++) begin
            isd = (k % 2 == 0);
            applyStimulus(~isd, 32'h40 + 4 * k, isd, 1'b0, 4'hF, 32'h500 + 4 * k, 32'h0, 1'b1, 1'b0, 32'h0);
            checkOutput("lat_d_gnt", {31'b0, d_gnt}, {31'b0, isd});
            checkOutput("lat_i_gnt", {31'b0, i_gnt}, {31'b0, ~isd});
            for (int w = 0; w < 4; w++) begin
                applyStimulus(isd, 32'h40, ~isd, 1'b0, 4'hF, 32'h600, 32'h0, 1'b1, 1'b0, 32'h0);
                checkOutput("lat_busy_m_req", {31'b0, m_req}, 32'h0);
                checkOutput("lat_busy_gnt", {30'b0, i_gnt, d_gnt}, 32'h0);
            end
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hF00 + k);
            expectResp(isd, 32'hF00 + k);
        end
        idleCycle();
        checkOutput("proto_err_still_set", {31'b0, proto_err}, 32'h1);

        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("proto_err_cleared", {31'b0, proto_err}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int t = 0; t < 20 && sb_q.size() != 0; t++) begin
            @(negedge clk);
        end
        #3;
        checkOutput("scoreboard_drained", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
